// File: rtl/uart_rx.sv
// uart_rx - 8N1 asynchronous serial receiver with mid-bit sampling.
//
// The line is passed through a 2-FF synchronizer and every decision uses the
// synchronized copy only. A down-counting baud counter is reloaded on each
// sample event. The first sample is taken half a bit period after the falling
// edge. After that, samples are taken one full bit period apart. The FSM goes
// back to idle at the middle of the stop bit, so a start edge that follows
// immediately is not missed.
//
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
// between the data bits and the stop bit. With the feature enabled:
//   - a parity mismatch is reported on parity_err in the same cycle as rx_valid;
//   - the data byte is still delivered when parity_err is reported;
//   - a stop-bit error suppresses both rx_valid and parity_err.
// Without the macro, parity_err is tied to 0.
//
// Parameters:
//   CLK_FREQ   - system clock frequency in Hz
//   BAUDRATE   - line bit rate; DIV = CLK_FREQ/BAUDRATE must be >= 4
//   DATA_WIDTH - data bits per frame, LSB first (2..16)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx_line    in   asynchronous serial input, idle high
//   rx_data    out  last good word, held until the next valid frame
//   rx_valid   out  one-cycle pulse when rx_data is updated
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   parity_err out  one-cycle pulse with rx_valid on a parity mismatch
//   rx_busy    out  high while the FSM is not idle

module uart_rx #(
  parameter int unsigned CLK_FREQ   = 14745600,
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_line,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  rx_busy
);

  localparam int unsigned DIV = CLK_FREQ / BAUDRATE;
  localparam int unsigned CW  = $clog2(DIV);

  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  state_e                r_state, w_state_next;
  logic                  r_sync1, r_sync2;
  logic                  w_rx_s;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [3:0]            r_bit_cnt, w_bit_cnt_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid, w_valid_next;
  logic                  r_ferr, w_ferr_next;
  logic                  w_tick;
  logic                  w_stop_sample;
`ifdef UART_RX_PARITY_EN
  logic                  r_par_bad, w_par_bad_next;
  logic                  r_perr, w_perr_next;
`endif

  assign w_rx_s = r_sync2;
  assign w_tick = (r_cnt == '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_sync1   <= rx_line;
      r_sync2   <= r_sync1;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_valid   <= w_valid_next;
      r_ferr    <= w_ferr_next;
      if (w_valid_next) begin
        r_data <= r_shift;
      end
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_next;
      r_perr    <= w_perr_next;
`endif
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
`ifdef UART_RX_PARITY_EN
    w_par_bad_next = r_par_bad;
`endif
    unique case (r_state)
      StIdle: begin
        if (!w_rx_s) begin
          w_state_next = StStart;
          w_cnt_next   = HALF_LOAD;
        end
      end
      StStart: begin
        if (w_tick) begin
          if (!w_rx_s) begin
            w_state_next   = StData;
            w_cnt_next     = FULL_LOAD;
            w_bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
            w_par_bad_next = 1'b0;
`endif
          end else begin
            // Line is back high at mid-start: treat the edge as a glitch.
            w_state_next = StIdle;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StData: begin
        if (w_tick) begin
          w_shift_next   = {w_rx_s, r_shift[DATA_WIDTH-1:1]};
          w_bit_cnt_next = r_bit_cnt + 4'd1;
          w_cnt_next     = FULL_LOAD;
          if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = StParity;
`else
            w_state_next = StStop;
`endif
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (w_tick) begin
          // Even parity: data ones plus the parity bit must be even.
          w_par_bad_next = (^r_shift) ^ w_rx_s;
          w_cnt_next     = FULL_LOAD;
          w_state_next   = StStop;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
`else
        w_state_next = StIdle;
`endif
      end
      StStop: begin
        if (w_tick) begin
          // Leave at mid-stop so that a back-to-back start edge is seen.
          w_state_next = w_rx_s ? StIdle : StWaitHigh;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StWaitHigh: begin
        // A held-low line (break) must not be decoded as new frames.
        if (w_rx_s) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Output decode
  always_comb begin
    w_stop_sample = (r_state == StStop) && w_tick;
    w_valid_next  = w_stop_sample && w_rx_s;
    w_ferr_next   = w_stop_sample && !w_rx_s;
`ifdef UART_RX_PARITY_EN
    w_perr_next   = w_valid_next && r_par_bad;
`endif
    rx_busy       = (r_state != StIdle);
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int DIV = 128;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_EXP     = 1346;  // 2 + 64 + 10*128
  localparam int SPACING_EXP = 1408;  // 11 bits * 128
`else
  localparam int LAT_EXP     = 1218;  // 2 + 64 + 9*128
  localparam int SPACING_EXP = 1280;  // 10 bits * 128
`endif

  logic       clk;
  logic       rst_n;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int valid_cnt   = 0;
  int ferr_cnt    = 0;
  int perr_cnt    = 0;
  int busy_cyc    = 0;
  int illegal_cnt = 0;
  int         valid_cyc[$];
  logic [7:0] data_q[$];

  uart_rx #(
    .CLK_FREQ  (14745600),
    .BAUDRATE  (115200),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_line   (rx_line),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc.push_back(cyc);
      data_q.push_back(rx_data);
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
    if (rx_busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if ((frame_err === 1'b1 && (rx_valid === 1'b1 || parity_err === 1'b1)) ||
        (parity_err === 1'b1 && rx_valid !== 1'b1)) begin
      illegal_cnt <= illegal_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    tick(DIV);
  endtask

  // Start bit, data bits (LSB first) and, with parity, the correct even-parity bit
  task automatic send_head(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d);
    send_bit(1'b1);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  initial begin
    int t0, lat, v0, f0, p0, b0;
    rst_n   = 1'b0;
    rx_line = 1'b1;
    tick(5);
    chk("reset_rx_data", {24'd0, rx_data}, 32'h0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'h0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'h0);
    chk("reset_parity_err", {31'd0, parity_err}, 32'h0);
    chk("reset_rx_busy", {31'd0, rx_busy}, 32'h0);

    // Idle line
    rst_n = 1'b1;
    tick(2000);
    chk("idle_valid_pulses", valid_cnt, 0);
    chk("idle_ferr_pulses", ferr_cnt, 0);
    chk("idle_busy_cycles", busy_cyc, 0);

    // Single frame 0xA5, latency from the start edge
    t0 = cyc;
    send_frame(8'hA5);
    tick(10);
    chk("a5_valid_pulses", valid_cnt, 1);
    chk("a5_rx_data", {24'd0, rx_data}, 32'hA5);
    chk("a5_ferr_pulses", ferr_cnt, 0);
    lat = (valid_cyc.size() > 0) ? valid_cyc[0] - t0 - 1 : -1;
    vectors++;
    assert (lat >= LAT_EXP - 1 && lat <= LAT_EXP + 1) else begin
      miscompares++;
      $error("FAIL a5_latency: observed %0d required %0d+-1", lat, LAT_EXP);
    end

    // Back-to-back frames with no idle gap
    v0 = valid_cnt;
    send_frame(8'h00);
    send_frame(8'hFF);
    send_frame(8'h3C);
    tick(10);
    chk("b2b_valid_pulses", valid_cnt - v0, 3);
    chk("b2b_data0", {24'd0, data_q[v0]}, 32'h00);
    chk("b2b_data1", {24'd0, data_q[v0+1]}, 32'hFF);
    chk("b2b_data2", {24'd0, data_q[v0+2]}, 32'h3C);
    chk("b2b_spacing01", valid_cyc[v0+1] - valid_cyc[v0], SPACING_EXP);
    chk("b2b_spacing12", valid_cyc[v0+2] - valid_cyc[v0+1], SPACING_EXP);

    // 40-cycle low glitch on an idle line
    v0 = valid_cnt;
    f0 = ferr_cnt;
    b0 = busy_cyc;
    rx_line = 1'b0;
    tick(40);
    rx_line = 1'b1;
    tick(200);
    chk("glitch_valid_pulses", valid_cnt - v0, 0);
    chk("glitch_ferr_pulses", ferr_cnt - f0, 0);
    chk("glitch_busy_after", {31'd0, rx_busy}, 32'h0);
    vectors++;
    assert (busy_cyc - b0 >= 60 && busy_cyc - b0 <= 68) else begin
      miscompares++;
      $error("FAIL glitch_busy_cycles: observed %0d required 64+-4", busy_cyc - b0);
    end

    // 0x55 with a low stop bit, line held low (break)
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_head(8'h55);
    rx_line = 1'b0;
    tick(3000);
    chk("ferr_pulses", ferr_cnt - f0, 1);
    chk("ferr_no_valid", valid_cnt - v0, 0);
    chk("ferr_busy_in_break", {31'd0, rx_busy}, 32'h1);
    chk("ferr_data_held", {24'd0, rx_data}, 32'h3C);
    rx_line = 1'b1;
    tick(5);
    chk("ferr_busy_released", {31'd0, rx_busy}, 32'h0);
    send_frame(8'h12);
    tick(10);
    chk("after_ferr_valid", valid_cnt - v0, 1);
    chk("after_ferr_data", {24'd0, rx_data}, 32'h12);
    chk("after_ferr_ferr", ferr_cnt - f0, 1);

    // Reset asserted in the middle of the data bits of 0x81
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_line = 1'b0;
    tick(DIV / 2);
    chk("rst_busy_before", {31'd0, rx_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rx_data", {24'd0, rx_data}, 32'h0);
    chk("rst_mid_rx_busy", {31'd0, rx_busy}, 32'h0);
    chk("rst_mid_rx_valid", {31'd0, rx_valid}, 32'h0);
    chk("rst_mid_frame_err", {31'd0, frame_err}, 32'h0);
    rx_line = 1'b1;
    tick(20);
    rst_n = 1'b1;
    tick(DIV * 12);
    chk("rst_no_valid", valid_cnt - v0, 0);
    chk("rst_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h81);
    tick(10);
    chk("rst_then_valid", valid_cnt - v0, 1);
    chk("rst_then_data", {24'd0, rx_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
    v0 = valid_cnt;
    p0 = perr_cnt;
    send_frame_p(8'h01, 1'b1);
    tick(10);
    chk("par_good_valid", valid_cnt - v0, 1);
    chk("par_good_perr", perr_cnt - p0, 0);
    chk("par_good_data", {24'd0, rx_data}, 32'h01);
    send_frame_p(8'h01, 1'b0);
    tick(10);
    chk("par_bad_valid", valid_cnt - v0, 2);
    chk("par_bad_perr", perr_cnt - p0, 1);
`else
    p0 = 0;
    chk("no_parity_perr", perr_cnt - p0, 0);
`endif

    chk("pulse_exclusivity", illegal_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
